// File: rtl/pipe_stage_reg_pkg.sv
// Shared widths and control-bit positions for the pipeline stage registers.
package pipe_pkg;

  localparam int unsigned PIPE_CTRL_W = 5;
  localparam int unsigned PIPE_DATA_W = 54;

  // Bit positions inside the control vector.
  typedef enum int unsigned {
    CTRL_MEM_WRITE = 0,
    CTRL_MEM_READ  = 1,
    CTRL_REG_WRITE = 2,
    CTRL_WADDR_SEL = 3,
    CTRL_RES_SEL   = 4
  } ctrl_bit_e;

  // Per-boundary widths: IF/ID carries pc+instr, later stages carry operands and indices.
  localparam int unsigned IF_ID_CTRL_W  = 1;
  localparam int unsigned IF_ID_DATA_W  = 64;
  localparam int unsigned ID_EX_CTRL_W  = 5;
  localparam int unsigned ID_EX_DATA_W  = 54;
  localparam int unsigned EX_MEM_CTRL_W = 4;
  localparam int unsigned EX_MEM_DATA_W = 37;
  localparam int unsigned MEM_WB_CTRL_W = 3;
  localparam int unsigned MEM_WB_DATA_W = 37;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake bundle of one pipeline stage boundary.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned DATA_W = PIPE_DATA_W
);

  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  // Stage side.
  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );

  // Surrounding pipeline side.
  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// Skid entry S of a pipeline stage plus the mux choosing S or the input as main-register source.
// Only instantiated when PIPE_STAGE_SKID_EN is defined.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned DATA_W = PIPE_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              drain,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] sel_ctrl,
  output logic [DATA_W-1:0] sel_data
);

  logic              s_valid;
  logic [CTRL_W-1:0] s_ctrl;
  logic [DATA_W-1:0] s_data;

  always_ff @(posedge clock) begin
    if (!reset) begin
      s_valid <= 1'b0;
      s_ctrl  <= '0;
      s_data  <= '0;
    end else if (flush) begin
      s_valid <= 1'b0;
    end else if (load) begin
      s_valid <= 1'b1;
      s_ctrl  <= in_ctrl;
      s_data  <= in_data;
    end else if (drain) begin
      s_valid <= 1'b0;
    end
  end

  // An occupied S is always older than the input, so it wins the mux.
  assign valid    = s_valid;
  assign sel_ctrl = s_valid ? s_ctrl : in_ctrl;
  assign sel_data = s_valid ? s_data : in_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with stall, flush and bubble-zeroed control.
// Define PIPE_STAGE_SKID_EN to add a skid entry and register in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned DATA_W = PIPE_DATA_W
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  pipe_stage_reg_if.slave stage
);

  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;

  logic              accept;
  logic              consume;
  logic              m_load;
  logic [CTRL_W-1:0] src_ctrl;
  logic [DATA_W-1:0] src_data;

  assign consume = m_valid && stage.out_ready;
  // A flushed cycle drops the offered beat even though in_ready may be high.
  assign accept  = stage.in_valid && stage.in_ready && !flush;

`ifdef PIPE_STAGE_SKID_EN
  logic s_valid;
  logic s_load;
  logic s_drain;

  assign stage.in_ready = !s_valid;
  assign s_drain        = consume && s_valid;
  assign s_load         = accept && m_valid && (!consume || s_valid);
  assign m_load         = consume ? (s_valid || accept) : (accept && !m_valid);

  pipe_skid_buf #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .load     (s_load),
    .drain    (s_drain),
    .in_ctrl  (stage.in_ctrl),
    .in_data  (stage.in_data),
    .valid    (s_valid),
    .sel_ctrl (src_ctrl),
    .sel_data (src_data)
  );
`else
  assign stage.in_ready = !m_valid || stage.out_ready;
  assign m_load         = accept;
  assign src_ctrl       = stage.in_ctrl;
  assign src_data       = stage.in_data;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      m_valid <= 1'b0;
      m_ctrl  <= '0;
      m_data  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (m_load) begin
      m_valid <= 1'b1;
      m_ctrl  <= src_ctrl;
      m_data  <= src_data;
    end else if (consume) begin
      m_valid <= 1'b0;
    end
  end

  assign stage.out_valid = m_valid;
  assign stage.out_ctrl  = m_valid ? m_ctrl : '0;
  assign stage.out_data  = m_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed check of pipe_stage_reg against a queue-based model of held beats.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned CW = 5;
  localparam int unsigned DW = 54;
`ifdef PIPE_STAGE_SKID_EN
  localparam int unsigned CAP   = 2;
  localparam int unsigned EXTRA = 1;
`else
  localparam int unsigned CAP   = 1;
  localparam int unsigned EXTRA = 0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic flush;

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus ();

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .stage (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else passes++;
  endtask

  // Model: FIFO of held beats (capacity 1 or 2) plus the last beat shown at the head.
  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         q[$];
  logic [DW-1:0] last_data = '0;
  bit            known = 1'b0;
  bit            rdy_now;

  function automatic bit exp_ready();
    if (CAP == 2) return q.size() < 2;
    return q.size() == 0 || bus.out_ready === 1'b1;
  endfunction

  always @(posedge clock) begin
    rdy_now = exp_ready();
    if (!reset) begin
      q.delete();
      last_data = '0;
      known = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && rdy_now) q.push_back('{bus.in_ctrl, bus.in_data});
      if (q.size() > 0) last_data = q[0].data;
    end
  end

  always @(negedge clock) begin
    if (known) begin
      logic          ev;
      logic [CW-1:0] ec;
      ev = q.size() > 0;
      ec = '0;
      if (ev) ec = q[0].ctrl;
      check("out_valid", 64'(bus.out_valid), 64'(ev));
      check("out_ctrl",  64'(bus.out_ctrl),  64'(ec));
      check("out_data",  64'(bus.out_data),  64'(last_data));
      check("in_ready",  64'(bus.in_ready),  64'(exp_ready()));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    bus.in_valid = v;
    bus.in_ctrl  = c;
    bus.in_data  = d;
  endtask

  int extra;

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 5'h1F, 54'h3FF);
    step();
    step();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_ctrl",  64'(bus.out_ctrl),  64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    reset = 1'b1;
    drive(1'b0, '0, '0);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    step();

    // Streaming
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'h03, DW'(i));
      step();
      check("stream_valid", 64'(bus.out_valid), 64'd1);
      check("stream_data",  64'(bus.out_data),  64'(i));
      check("stream_ctrl",  64'(bus.out_ctrl),  64'h03);
    end
    drive(1'b0, '0, '0);
    step();

    // Stall
    drive(1'b1, 5'h03, 54'hBEEF);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    drive(1'b1, 5'h03, 54'hB0B);
    extra = 0;
    repeat (4) begin
      #1;
      if (bus.in_ready) extra++;
      step();
      check("stall_data",  64'(bus.out_data),  64'hBEEF);
      check("stall_valid", 64'(bus.out_valid), 64'd1);
    end
    check("stall_extra", 64'(extra), 64'(EXTRA));
    drive(1'b0, '0, '0);
    bus.out_ready = 1'b1;
    step();
    if (EXTRA == 1) begin
      check("release_b_valid", 64'(bus.out_valid), 64'd1);
      check("release_b_data",  64'(bus.out_data),  64'hB0B);
    end else begin
      check("release_valid", 64'(bus.out_valid), 64'd0);
    end
    step();
    check("drained_valid", 64'(bus.out_valid), 64'd0);

    // Flush
    bus.out_ready = 1'b0;
    drive(1'b1, 5'h05, 54'h55);
    step();
    check("pre_flush_ctrl", 64'(bus.out_ctrl), 64'h05);
    flush = 1'b1;
    drive(1'b1, 5'h03, 54'h7);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    check("flush_ctrl",  64'(bus.out_ctrl),  64'd0);
    check("flush_data",  64'(bus.out_data),  64'h55);
    bus.out_ready = 1'b1;
    repeat (3) begin
      step();
      check("flush_no_7", 64'(bus.out_valid), 64'd0);
    end

    // Bubble
    drive(1'b1, 5'h1F, 54'h1234);
    step();
    check("bubble_pre_ctrl", 64'(bus.out_ctrl), 64'h1F);
    drive(1'b0, '0, '0);
    step();
    check("bubble_valid", 64'(bus.out_valid), 64'd0);
    check("bubble_ctrl",  64'(bus.out_ctrl),  64'd0);
    check("bubble_data",  64'(bus.out_data),  64'h1234);

`ifdef PIPE_STAGE_SKID_EN
    // Skid full then drain
    bus.out_ready = 1'b0;
    drive(1'b1, 5'h03, 54'hA1);
    step();
    drive(1'b1, 5'h03, 54'hA2);
    step();
    drive(1'b1, 5'h03, 54'hA3);
    #1;
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    #1;
    check("pulse_in_ready", 64'(bus.in_ready), 64'd1);
    check("pulse_data",     64'(bus.out_data), 64'hA2);
    drive(1'b0, '0, '0);
    bus.out_ready = 1'b1;
    repeat (4) step();
`endif

    // Reset in the middle of a stall: nothing replays afterwards
    bus.out_ready = 1'b0;
    drive(1'b1, 5'h04, 54'h99);
    step();
    reset = 1'b0;
    drive(1'b0, '0, '0);
    step();
    reset = 1'b1;
    check("midrst_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_data",  64'(bus.out_data),  64'd0);
    bus.out_ready = 1'b1;
    step();
    check("midrst_no_replay", 64'(bus.out_valid), 64'd0);

    // Random traffic
    repeat (3000) begin
      reset = ($urandom_range(0, 99) != 0);
      flush = ($urandom_range(0, 19) == 0);
      drive(1'($urandom_range(0, 1)), CW'($urandom()), DW'({$urandom(), $urandom()}));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    reset = 1'b1;
    flush = 1'b0;
    drive(1'b0, '0, '0);
    step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
